// File: rtl/pipeline_skid_buffer.sv
// Two-entry skid buffer (output register + skid register) that registers the
// upstream ready. Define PIPELINE_SKID_PASSTHROUGH_EN for a 0-latency bypass in EMPTY.
module pipeline_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_data_valid,
  output logic                  s_data_ready,
  input  logic [DATA_WIDTH-1:0] s_data_data,
  output logic                  m_data_valid,
  input  logic                  m_data_ready,
  output logic [DATA_WIDTH-1:0] m_data_data,
  input  logic                  s_ctrl_flush,
  input  logic                  s_ctrl_stall,
  output logic                  s_status_busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] out_q, out_next;
  logic [DATA_WIDTH-1:0] skid_q, skid_next;
  logic                  in_xfer, out_xfer;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      out_q  <= out_next;
      skid_q <= skid_next;
    end
  end

  always_comb begin
    state_next = state;
    out_next   = out_q;
    skid_next  = skid_q;
    in_xfer    = s_data_valid && s_data_ready;
    out_xfer   = m_data_valid && m_data_ready;
    if (s_ctrl_flush) begin
      state_next = EMPTY;
      out_next   = '0;
      skid_next  = '0;
    end else if (!s_ctrl_stall) begin
      unique case (state)
        EMPTY: begin
`ifdef PIPELINE_SKID_PASSTHROUGH_EN
          // A bypassed beat that completes downstream leaves nothing to hold.
          if (in_xfer && !out_xfer) begin
            out_next   = s_data_data;
            state_next = ONE;
          end
`else
          if (in_xfer) begin
            out_next   = s_data_data;
            state_next = ONE;
          end
`endif
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_next = s_data_data;
          end else if (in_xfer) begin
            skid_next  = s_data_data;
            state_next = TWO;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            out_next   = skid_q;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Upstream ready depends on state and stall only, never on m_data_ready.
  always_comb begin
    s_data_ready  = (state != TWO) && !s_ctrl_stall;
    m_data_valid  = (state != EMPTY) && !s_ctrl_stall;
    m_data_data   = out_q;
    s_status_busy = (state != EMPTY);
`ifdef PIPELINE_SKID_PASSTHROUGH_EN
    if (state == EMPTY && rst_ni) begin
      m_data_valid = s_data_valid && !s_ctrl_stall;
      m_data_data  = s_data_data;
    end
`endif
  end

endmodule
